// File: rtl/siso_shift_ctrl_pkg.sv
// Shared types and width helpers for the SISO shift-register sequencer.
package siso_shift_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/siso_shift_ctrl_cnt.sv
// Loadable up-counter with synchronous clear, count enable and terminal-count compare.
module siso_shift_ctrl_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] q,
  output logic         tc
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (ld) begin
      q <= ld_val;
    end else if (en) begin
      q <= q + W'(1);
    end
  end

  assign tc = (q == term);

endmodule

// File: rtl/siso_shift_ctrl.sv
// Sequencer feeding a SISO shift register: one load cycle, WIDTH enable cycles, done pulse, GAP idle cycles.
// Optional SISO_SHIFT_PAUSE_EN adds a pause input that freezes the shift sequence.
module siso_shift_ctrl
  import siso_shift_ctrl_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int GAP   = 1,
  localparam int CW    = cnt_width(WIDTH),
  localparam int GW    = cnt_width(GAP)
) (
  input  logic             clk,
  input  logic             areset,
`ifdef SISO_SHIFT_PAUSE_EN
  input  logic             pause,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             sr_load,
  output logic             sr_ena,
  output logic [WIDTH-1:0] sr_data,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    shift_cnt
);

  localparam int GAP_TERM = (GAP > 0) ? GAP - 1 : 0;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] hold;
  logic             done_q;
  logic             advance;
  logic             take;
  logic             last_shift;
  logic [CW-1:0]    cnt;
  logic             cnt_tc;
  logic [GW-1:0]    gap_cnt_unused;
  logic             gap_tc;

`ifdef SISO_SHIFT_PAUSE_EN
  assign advance = ~pause;
`else
  assign advance = 1'b1;
`endif

  assign take       = (state == S_IDLE) && in_valid;
  assign last_shift = (state == S_SHIFT) && advance && cnt_tc;

  always_ff @(posedge clk) begin
    if (areset) begin
      state  <= S_IDLE;
      hold   <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= last_shift;
      if (take) begin
        hold <= in_data;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (in_valid) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_SHIFT;
      S_SHIFT: if (last_shift) state_nxt = (GAP > 0) ? S_GAP : S_IDLE;
      S_GAP:   if (gap_tc) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Shift count reads WIDTH during the done cycle and clears as that cycle ends.
  siso_shift_ctrl_cnt #(.W(CW)) u_shift_cnt (
    .clk    (clk),
    .rst    (areset),
    .clr    (done_q),
    .ld     (1'b0),
    .ld_val ('0),
    .en     ((state == S_SHIFT) && advance),
    .term   (CW'(WIDTH - 1)),
    .q      (cnt),
    .tc     (cnt_tc)
  );

  siso_shift_ctrl_cnt #(.W(GW)) u_gap_cnt (
    .clk    (clk),
    .rst    (areset),
    .clr    ((state == S_GAP) && gap_tc),
    .ld     (1'b0),
    .ld_val ('0),
    .en     (state == S_GAP),
    .term   (GW'(GAP_TERM)),
    .q      (gap_cnt_unused),
    .tc     (gap_tc)
  );

  assign in_ready  = (state == S_IDLE) && !areset;
  assign sr_load   = (state == S_LOAD);
  assign sr_ena    = (state == S_SHIFT) && advance;
  assign sr_data   = hold;
  assign busy      = (state != S_IDLE);
  assign done      = done_q;
  assign shift_cnt = cnt;

endmodule
